// File: rtl/envelope_gen.sv
// envelope_gen: per-voice ADSR envelope producing a linear Q16.16 gain ramp.
// Each segment's per-sample step comes from a 32-cycle restoring divider.
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 8
`endif

module envelope_gen #(
  parameter int ENVELOPE_LEN = `ENVELOPE_LEN,
  parameter int SUSTAIN_IDX  = 2,
  parameter int SEG_W        = $clog2(ENVELOPE_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic [ENVELOPE_LEN*64-1:0] envelopes,
  input  logic [7:0]                cmds,
  output logic [31:0]               gain_out,
  output logic                      active,
  output logic [SEG_W-1:0]          segment
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_SUST  = 2'd3;

  localparam logic [SEG_W-1:0] SEG_SUS  = SEG_W'(SUSTAIN_IDX);
  localparam logic [SEG_W-1:0] SEG_REL  = SEG_W'(SUSTAIN_IDX + 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(ENVELOPE_LEN - 1);

  // Entry 0 sits in the top 64 bits; gain above duration.
  logic [31:0] env_gain [ENVELOPE_LEN];
  logic [31:0] env_dur  [ENVELOPE_LEN];

  for (genvar i = 0; i < ENVELOPE_LEN; i++) begin : g_env
    localparam int B = (ENVELOPE_LEN - 1 - i) * 64;
    assign env_gain[i] = envelopes[B+32 +: 32];
    assign env_dur[i]  = envelopes[B +: 32];
  end

  logic [1:0]       state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [31:0]      gain_q, gain_d;
  logic             gate_q;
  logic             pend_q, pend_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      dur_q, dur_d;
  logic [31:0]      remain_q, remain_d;
  logic             dir_q, dir_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;

  logic gate, rise, fall;
  logic do_adv;

  assign gate = cmds[0];
  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  logic unused_cmds;
  assign unused_cmds = ^cmds[7:1];

  logic [31:0] l_tgt, l_dur, l_diff;
  logic        l_up;

  assign l_tgt  = env_gain[seg_q];
  assign l_dur  = env_dur[seg_q];
  assign l_up   = l_tgt >= gain_q;
  assign l_diff = l_up ? l_tgt - gain_q : gain_q - l_tgt;

  // Remainder stays below the divisor, so the shifted value fits 33 bits.
  logic [32:0] rem_sh, rem_dif;
  logic        div_ge;

  assign rem_sh  = {rem_q, quo_q[31]};
  assign rem_dif = rem_sh - {1'b0, dur_q};
  assign div_ge  = ~rem_dif[32];

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    gain_d   = gain_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    dur_d    = dur_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    do_adv   = 1'b0;
    if (rise) begin
      state_d = S_SETUP;
      seg_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (fall && state_q != S_IDLE &&
                 seg_q <= SEG_SUS) begin
      state_d = S_SETUP;
      seg_d   = SEG_REL;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_SETUP: begin
          pend_d = pend_q | sample_tick;
          if (cnt_q == 6'd0) begin
            target_d = l_tgt;
            dur_d    = l_dur;
            remain_d = l_dur;
            dir_d    = l_up;
            quo_d    = l_diff;
            rem_d    = '0;
            if (l_dur == 32'd0) begin
              gain_d = l_tgt;
              do_adv = 1'b1;
            end else begin
              cnt_d = 6'd1;
            end
          end else begin
            quo_d = {quo_q[30:0], div_ge};
            rem_d = div_ge ? rem_dif[31:0] : rem_sh[31:0];
            if (cnt_q == 6'd32) begin
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        S_RUN: begin
          if (sample_tick || pend_q) begin
            pend_d   = 1'b0;
            remain_d = remain_q - 32'd1;
            // Last step lands exactly on target, absorbing truncation.
            if (remain_q == 32'd1) begin
              gain_d = target_q;
              do_adv = 1'b1;
            end else begin
              gain_d = dir_q ? gain_q + quo_q
                             : gain_q - quo_q;
            end
          end
        end
        default: ;
      endcase
      if (do_adv) begin
        cnt_d = '0;
        if (seg_q == SEG_SUS) begin
          if (gate) begin
            state_d = S_SUST;
            pend_d  = 1'b0;
          end else begin
            state_d = S_SETUP;
            seg_d   = SEG_REL;
          end
        end else if (seg_q == SEG_LAST) begin
          state_d = S_IDLE;
          gain_d  = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = S_SETUP;
          seg_d   = seg_q + SEG_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      seg_q    <= '0;
      gain_q   <= '0;
      gate_q   <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      target_q <= '0;
      dur_q    <= '0;
      remain_q <= '0;
      dir_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      gain_q   <= gain_d;
      gate_q   <= gate;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      dur_q    <= dur_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  assign gain_out = gain_q;
  assign active   = state_q != S_IDLE;
  assign segment  = seg_q;

endmodule

// File: tb/tb_envelope_gen.sv
// tb_envelope_gen: directed envelope scenarios plus a randomized run
// against a sample-level behavioural envelope model.
module tb_envelope_gen;
  localparam int LEN = 8;
  localparam int SI  = 1;

  logic               clk;
  logic               rst;
  logic               sample_tick;
  logic [LEN*64-1:0]  envelopes;
  logic [7:0]         cmds;
  logic [31:0]        gain_out;
  logic               active;
  logic [2:0]         segment;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] e_gain [LEN];
  logic [31:0] e_dur  [LEN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  envelope_gen #(
    .ENVELOPE_LEN(LEN),
    .SUSTAIN_IDX (SI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .envelopes  (envelopes),
    .cmds       (cmds),
    .gain_out   (gain_out),
    .active     (active),
    .segment    (segment)
  );

  // Reference model: modes 0 idle, 1 setup, 2 run, 3 sustain
  int          m_mode = 0;
  int          m_seg = 0;
  int          m_left = 0;
  logic [31:0] m_gain = 0;
  logic [31:0] m_tgt = 0;
  logic [31:0] m_dur = 0;
  logic [31:0] m_step = 0;
  logic [31:0] m_remain = 0;
  logic        m_up = 0;
  logic        m_prev = 0;
  logic        m_pend = 0;
  logic        m_latched = 0;

  task automatic pack_env();
    for (int i = 0; i < LEN; i++)
      envelopes[(LEN-1-i)*64 +: 64] = {e_gain[i], e_dur[i]};
  endtask

  task automatic set_env(input int i, input logic [31:0] g,
                         input logic [31:0] d);
    e_gain[i] = g;
    e_dur[i]  = d;
    pack_env();
  endtask

  task automatic clear_env();
    for (int i = 0; i < LEN; i++) begin
      e_gain[i] = 0;
      e_dur[i]  = 0;
    end
    pack_env();
  endtask

  task automatic m_enter(input int s);
    m_mode    = 1;
    m_seg     = s;
    m_latched = 0;
  endtask

  task automatic m_finish(input logic g);
    m_gain = m_tgt;
    if (m_seg == SI) begin
      if (g) begin
        m_mode = 3;
        m_pend = 0;
      end else m_enter(SI + 1);
    end else if (m_seg == LEN - 1) begin
      m_mode = 0;
      m_gain = 0;
      m_pend = 0;
    end else m_enter(m_seg + 1);
  endtask

  task automatic model_clock();
    logic g;
    logic rise, fall;
    g = cmds[0];
    if (rst) begin
      m_mode = 0; m_seg = 0; m_gain = 0;
      m_prev = 0; m_pend = 0; m_latched = 0;
      return;
    end
    rise = g && !m_prev;
    fall = !g && m_prev;
    m_prev = g;
    if (rise) begin
      m_enter(0);
      m_pend = 0;
    end else if (fall && m_mode != 0 && m_seg <= SI) begin
      m_enter(SI + 1);
      m_pend = 0;
    end else if (m_mode == 1) begin
      if (sample_tick) m_pend = 1;
      if (!m_latched) begin
        m_tgt = e_gain[m_seg];
        m_dur = e_dur[m_seg];
        m_latched = 1;
        if (m_dur == 0) m_finish(g);
        else begin
          m_up = m_tgt >= m_gain;
          m_step = (m_up ? m_tgt - m_gain : m_gain - m_tgt) / m_dur;
          m_remain = m_dur;
          m_left = 32;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (sample_tick || m_pend) begin
        m_pend = 0;
        m_remain--;
        if (m_remain == 0) m_finish(g);
        else m_gain = m_up ? m_gain + m_step : m_gain - m_step;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic apply_reset();
    cmds = 8'h00;
    sample_tick = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmds = 8'h00;
    sample_tick = 1'b0;
    clear_env();
    cyc();
    cyc();
    n_vec++;
    if (gain_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_gain got %h want 0", gain_out);
    end
    n_vec++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_active got %b want 0", active);
    end
    n_vec++;
    if (segment !== 3'd0) begin
      n_err++;
      $display("FAIL reset_segment got %0d want 0", segment);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_attack();
    logic [31:0] exp_g [3];
    exp_g[0] = 32'h8000;
    exp_g[1] = 32'hC000;
    exp_g[2] = 32'h10000;
    apply_reset();
    clear_env();
    set_env(0, 32'h10000, 4);
    set_env(1, 32'h10000, 0);
    cmds = 8'h01;
    cyc();
    n_vec++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL attack_active got %b want 1", active);
    end
    idle(3);
    tick();
    idle(29);
    n_vec++;
    if (gain_out !== 32'h0) begin
      n_err++;
      $display("FAIL attack_pre_run got %h want 0", gain_out);
    end
    cyc();
    n_vec++;
    if (gain_out !== 32'h4000) begin
      n_err++;
      $display("FAIL attack_first_step got %h want 4000", gain_out);
    end
    for (int k = 0; k < 3; k++) begin
      idle(40);
      tick();
      n_vec++;
      if (gain_out !== exp_g[k]) begin
        n_err++;
        $display("FAIL attack_step%0d got %h want %h", k + 1, gain_out, exp_g[k]);
      end
    end
    idle(3);
    n_vec++;
    if (segment !== 3'd1 || active !== 1'b1) begin
      n_err++;
      $display("FAIL attack_sustain seg %0d act %b want 1 1", segment, active);
    end
  endtask

  task automatic test_trunc();
    logic [31:0] exp_g [3];
    exp_g[0] = 32'h5555;
    exp_g[1] = 32'hAAAA;
    exp_g[2] = 32'h10000;
    apply_reset();
    clear_env();
    set_env(0, 32'h10000, 3);
    set_env(1, 32'h10000, 0);
    cmds = 8'h01;
    for (int k = 0; k < 3; k++) begin
      idle(40);
      tick();
      n_vec++;
      if (gain_out !== exp_g[k]) begin
        n_err++;
        $display("FAIL trunc_step%0d got %h want %h", k + 1, gain_out, exp_g[k]);
      end
    end
  endtask

  task automatic test_sustain_release();
    apply_reset();
    clear_env();
    set_env(0, 32'h10000, 0);
    set_env(1, 32'h8000, 2);
    set_env(2, 32'h0, 2);
    cmds = 8'h01;
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'hC000) begin
      n_err++;
      $display("FAIL decay_step1 got %h want c000", gain_out);
    end
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'h8000) begin
      n_err++;
      $display("FAIL decay_step2 got %h want 8000", gain_out);
    end
    for (int k = 0; k < 100; k++) begin
      idle(3);
      tick();
      n_vec++;
      if (gain_out !== 32'h8000 || active !== 1'b1) begin
        n_err++;
        $display("FAIL sustain_hold%0d got %h act %b want 8000 1", k, gain_out, active);
      end
    end
    cmds = 8'h00;
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'h4000) begin
      n_err++;
      $display("FAIL release_step1 got %h want 4000", gain_out);
    end
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'h0) begin
      n_err++;
      $display("FAIL release_step2 got %h want 0", gain_out);
    end
    idle(10);
    n_vec++;
    if (active !== 1'b0 || gain_out !== 32'h0) begin
      n_err++;
      $display("FAIL release_idle act %b gain %h want 0 0", active, gain_out);
    end
  endtask

  task automatic test_zero_dur();
    apply_reset();
    clear_env();
    set_env(0, 32'h20000, 0);
    set_env(1, 32'h20000, 5);
    cmds = 8'h01;
    cyc();
    cyc();
    n_vec++;
    if (gain_out !== 32'h20000) begin
      n_err++;
      $display("FAIL zero_dur_gain got %h want 20000", gain_out);
    end
    n_vec++;
    if (segment !== 3'd1) begin
      n_err++;
      $display("FAIL zero_dur_segment got %0d want 1", segment);
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    clear_env();
    set_env(0, 32'h10000, 4);
    set_env(1, 32'h10000, 0);
    set_env(2, 32'h0, 2);
    cmds = 8'h01;
    idle(40);
    tick();
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'h8000) begin
      n_err++;
      $display("FAIL early_attack got %h want 8000", gain_out);
    end
    cmds = 8'h00;
    idle(40);
    n_vec++;
    if (segment !== 3'd2) begin
      n_err++;
      $display("FAIL early_rel_seg got %0d want 2", segment);
    end
    tick();
    n_vec++;
    if (gain_out !== 32'h4000) begin
      n_err++;
      $display("FAIL early_rel_step got %h want 4000", gain_out);
    end
    idle(5);
    cmds = 8'h01;
    cyc();
    n_vec++;
    if (segment !== 3'd0) begin
      n_err++;
      $display("FAIL retrig_seg got %0d want 0", segment);
    end
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'h7000) begin
      n_err++;
      $display("FAIL retrig_step got %h want 7000", gain_out);
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_vec++;
    if (gain_out !== 32'h0 || active !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear gain %h act %b want 0 0", gain_out, active);
    end
    cyc();
    n_vec++;
    if (active !== 1'b1 || segment !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_retrig act %b seg %0d want 1 0", active, segment);
    end
    idle(40);
    tick();
    n_vec++;
    if (gain_out !== 32'h4000) begin
      n_err++;
      $display("FAIL midrst_ramp got %h want 4000", gain_out);
    end
  endtask

  task automatic test_random();
    int gap;
    int since;
    apply_reset();
    for (int i = 0; i < LEN; i++)
      set_env(i, $urandom(),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5));
    gap = $urandom_range(40, 60);
    since = 0;
    for (int c = 0; c < 8000; c++) begin
      since++;
      sample_tick = (since >= gap);
      if (sample_tick) begin
        since = 0;
        gap = $urandom_range(40, 60);
      end
      if ($urandom_range(0, 399) == 0) cmds[0] = ~cmds[0];
      if ($urandom_range(0, 149) == 0)
        set_env($urandom_range(0, LEN - 1), $urandom(),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5));
      rst = ($urandom_range(0, 1999) == 0);
      cyc();
      n_vec++;
      if (gain_out !== m_gain) begin
        n_err++;
        $display("FAIL rand_gain cyc %0d got %h want %h", c, gain_out, m_gain);
      end
      n_vec++;
      if (active !== (m_mode != 0)) begin
        n_err++;
        $display("FAIL rand_active cyc %0d got %b want %b", c, active, m_mode != 0);
      end
      n_vec++;
      if (segment !== 3'(m_seg)) begin
        n_err++;
        $display("FAIL rand_segment cyc %0d got %0d want %0d", c, segment, m_seg);
      end
    end
    sample_tick = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmds = 8'h00;
    sample_tick = 1'b0;
    envelopes = '0;
    test_reset();
    test_attack();
    test_trunc();
    test_sustain_release();
    test_zero_dur();
    test_early_release();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
